// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - drains the capture FIFO one byte at a time onto an 8N1 UART TX line.
// Optional even-parity bit after the data bits when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT  = 16,
  parameter int READY_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       fifo_empty,
  output logic       fifo_read,
  input  logic       fifo_data_ready,
  input  logic [7:0] fifo_data,
  output logic       tx,
  output logic       busy,
  output logic       timeout_err
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int WAIT_W = $clog2(READY_TIMEOUT + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READY_TIMEOUT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REQ    = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] START  = 3'd3;
  localparam logic [2:0] DATA   = 3'd4;
  localparam logic [2:0] STOP   = 3'd5;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd6;
  localparam logic [2:0] AFTER_DATA = PARITY;
  logic parity;
`else
  localparam logic [2:0] AFTER_DATA = STOP;
`endif

  logic [2:0]        state;
  logic [BAUD_W-1:0] baud;
  logic [WAIT_W-1:0] wait_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic              baud_done;

  assign baud_done = (baud == BAUD_LAST);
  assign fifo_read = (state == REQ);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      baud        <= '0;
      wait_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      timeout_err <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (enable && !fifo_empty) state <= REQ;
        end
        REQ: begin
          state    <= WAIT;
          wait_cnt <= '0;
          baud     <= '0;
        end
        WAIT: begin
          // fifo_data_ready is only honoured here; a late pulse after timeout is dropped.
          if (fifo_data_ready) begin
            shreg <= fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
            parity <= ^fifo_data;
`endif
            baud  <= '0;
            state <= START;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        START: begin
          if (baud_done) begin
            baud    <= '0;
            bit_cnt <= '0;
            state   <= DATA;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud    <= '0;
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= AFTER_DATA;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            baud  <= '0;
            state <= STOP;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
`endif
        STOP: begin
          if (baud_done) begin
            baud  <= '0;
            state <= IDLE;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // tx is decoded from state so a reset edge returns the line high immediately.
  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shreg[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  tx = parity;
`endif
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed table-driven bench for fifo_uart_tx (CLKS_PER_BIT=4, READY_TIMEOUT=4).
module tb_fifo_uart_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       fifo_empty = 1'b1;
  logic       fifo_read;
  logic       fifo_data_ready = 1'b0;
  logic [7:0] fifo_data = 8'h00;
  logic       tx;
  logic       busy;
  logic       timeout_err;

  int tests = 0;
  int fails = 0;
  int reads = 0;
  bit respond = 1'b1;
  bit pending = 1'b0;
  logic [7:0] pend_byte = 8'h00;
  logic [7:0] q[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par;
  } vec_t;
  vec_t vecs[4];

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .READY_TIMEOUT(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .fifo_empty(fifo_empty),
    .fifo_read(fifo_read),
    .fifo_data_ready(fifo_data_ready),
    .fifo_data(fifo_data),
    .tx(tx),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // FIFO model: answers a read strobe with a one-cycle data_ready on the following cycle.
  always @(negedge clk) begin
    fifo_data_ready = 1'b0;
    if (pending && respond) begin
      fifo_data_ready = 1'b1;
      fifo_data = pend_byte;
    end
    pending = 1'b0;
    if (fifo_read === 1'b1) begin
      reads++;
      if (q.size() > 0) pend_byte = q.pop_front();
      pending = 1'b1;
    end
    fifo_empty = (q.size() == 0);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_read(input string nm);
    int n = 0;
    while (fifo_read !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_read"}, 32'(fifo_read), 32'd1);
  endtask

  // Entered on the sample where fifo_read is high; leaves on the first cycle after STOP.
  task automatic check_frame(input string nm, input logic [9:0] fr, input logic par);
    logic [10:0] seq;
    int nb;
    logic ok;
`ifdef FIFO_UART_TX_PARITY_EN
    seq = {fr[9], par, fr[8:0]};
    nb = 11;
`else
    seq = {par, fr};
    nb = 10;
`endif
    @(negedge clk);
    check({nm, "_wait"}, 32'({tx, fifo_read, busy}), 32'b101);
    @(negedge clk);
    for (int b = 0; b < nb; b++) begin
      ok = 1'b1;
      for (int c = 0; c < CPB; c++) begin
        if (tx !== seq[b] || busy !== 1'b1 || fifo_read !== 1'b0) ok = 1'b0;
        @(negedge clk);
      end
      check($sformatf("%s_bit%0d", nm, b), 32'(ok), 32'd1);
    end
    check({nm, "_end"}, 32'({tx, busy}), 32'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h3C, 10'b1001111000, 1'b0};
    vecs[1] = '{8'h07, 10'b1000001110, 1'b1};
    vecs[2] = '{8'h03, 10'b1000000110, 1'b0};
    vecs[3] = '{8'hC3, 10'b1110000110, 1'b0};

    // Reset held with a non-empty FIFO and enable high.
    q.push_back(8'hA5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_c%0d", i), 32'({tx, fifo_read, busy, timeout_err}), 32'b1000);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_release_read", 32'(fifo_read), 32'd1);
    check_frame("a5", 10'b1101001010, 1'b0);
    check("a5_reads", 32'(reads), 32'd1);

    for (int i = 0; i < 4; i++) begin
      q.push_back(vecs[i].data);
      wait_read($sformatf("vec%0d", i));
      check_frame($sformatf("vec%0d", i), vecs[i].frame, vecs[i].par);
    end

    // Back-to-back frames.
    reads = 0;
    q.push_back(8'h00);
    q.push_back(8'hFF);
    wait_read("b2b0");
    check_frame("b2b0", 10'b1000000000, 1'b0);
    @(negedge clk);
    check("b2b_gap_read", 32'(fifo_read), 32'd1);
    check_frame("b2b1", 10'b1111111110, 1'b0);
    begin
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
        if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        @(negedge clk);
      end
      check("b2b_idle_high", 32'(ok), 32'd1);
    end
    check("b2b_reads", 32'(reads), 32'd2);

    // Enable falling mid-frame: frame completes, then the block holds in IDLE.
    q.push_back(8'h81);
    q.push_back(8'h7E);
    wait_read("en0");
    enable = 1'b0;
    check_frame("en0", 10'b1100000010, 1'b0);
    begin
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 30; i++) begin
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_read !== 1'b0) ok = 1'b0;
        @(negedge clk);
      end
      check("en_hold_idle", 32'(ok), 32'd1);
    end
    enable = 1'b1;
    wait_read("en1");
    check_frame("en1", 10'b1011111100, 1'b0);

    // Timeout: FIFO never answers.
    respond = 1'b0;
    q.push_back(8'h99);
    wait_read("to");
    @(negedge clk);
    check("to_w0_err", 32'(timeout_err), 32'd0);
    repeat (3) @(negedge clk);
    check("to_w3_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    check("to_w4_state", 32'({timeout_err, busy, tx}), 32'b101);
    respond = 1'b1;
    q.push_back(8'h3C);
    wait_read("to_next");
    check_frame("to_next", 10'b1001111000, 1'b0);
    check("to_sticky", 32'(timeout_err), 32'd1);

    // Reset during DATA bit 3 of 0x55.
    q.push_back(8'h55);
    wait_read("mid");
    repeat (19) @(negedge clk);
    check("mid_bit3_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_reset", 32'({tx, busy, timeout_err}), 32'b100);
    @(negedge clk);
    rst_n = 1'b1;
    q.push_back(8'hA5);
    wait_read("post");
    check_frame("post", 10'b1101001010, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
